// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// Request/response bundle between the core issue logic and muldiv_seq_unit.
interface muldiv_seq_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, operand_a, operand_b,
                  input  busy, done, result);
  modport slave  (input  start, funct3, operand_a, operand_b,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: sign flags, magnitudes and the
// divide-by-zero / signed-overflow shortcuts that bypass the iteration.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] a_abs_c,
  output logic [XLEN-1:0] b_abs_c,
  output logic            neg_main_c,
  output logic            neg_rem_c,
  output logic            special_c,
  output logic [XLEN-1:0] special_res_c
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;

  always_comb begin
    a_signed      = funct3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed      = funct3 inside {OP_MULH, OP_DIV, OP_REM};
    a_neg         = a_signed & operand_a[XLEN-1];
    b_neg         = b_signed & operand_b[XLEN-1];
    a_abs_c       = a_neg ? -operand_a : operand_a;
    b_abs_c       = b_neg ? -operand_b : operand_b;
    neg_main_c    = a_neg ^ b_neg;
    neg_rem_c     = a_neg;
    div_zero      = funct3[2] & (operand_b == '0);
    div_ovf       = (funct3 inside {OP_DIV, OP_REM}) & (operand_a == MIN_NEG) & (&operand_b);
    special_c     = div_zero | div_ovf;
    special_res_c = '0;
    // funct3[1] selects the remainder flavour within the divide group
    if (div_zero) begin
      special_res_c = funct3[1] ? operand_a : '1;
    end else if (div_ovf) begin
      special_res_c = funct3[1] ? '0 : operand_a;
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input logic              clk,
  input logic              rst,
  muldiv_seq_unit_if.slave bus
);

  localparam int unsigned W2 = 2 * XLEN;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op;
  logic            neg_main, neg_rem;
  logic [W2-1:0]   acc, mcand;
  logic [XLEN-1:0] shreg, divisor, rem;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] a_abs_c, b_abs_c, special_res_c;
  logic            neg_main_c, neg_rem_c, special_c;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3        (bus.funct3),
    .operand_a     (bus.operand_a),
    .operand_b     (bus.operand_b),
    .a_abs_c       (a_abs_c),
    .b_abs_c       (b_abs_c),
    .neg_main_c    (neg_main_c),
    .neg_rem_c     (neg_rem_c),
    .special_c     (special_c),
    .special_res_c (special_res_c)
  );

  logic [W2-1:0]   mul_acc_nx, prod_fin;
  logic [XLEN-1:0] mplier_nx, quo_nx, rem_nx, quo_fin, rem_fin, res_fin;
  logic [XLEN:0]   div_shift, div_trial;
  logic            div_bit, last_c;

  // One datapath step plus the sign-corrected result of that step
  always_comb begin
    mul_acc_nx = acc + (shreg[0] ? mcand : '0);
    mplier_nx  = shreg >> 1;
    div_shift  = {rem, shreg[XLEN-1]};
    div_trial  = div_shift - {1'b0, divisor};
    div_bit    = ~div_trial[XLEN];
    rem_nx     = div_bit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_nx     = {shreg[XLEN-2:0], div_bit};
    prod_fin   = neg_main ? -mul_acc_nx : mul_acc_nx;
    quo_fin    = neg_main ? -quo_nx : quo_nx;
    rem_fin    = neg_rem ? -rem_nx : rem_nx;
    last_c     = (cnt == CNT_W'(XLEN - 1));
`ifdef MULDIV_EARLY_OUT_EN
    last_c     = last_c | (~op[2] & (mplier_nx == '0));
`endif
    case (op)
      OP_MUL:                       res_fin = mul_acc_nx[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_fin = prod_fin[W2-1:XLEN];
      OP_DIV, OP_DIVU:              res_fin = quo_fin;
      default:                      res_fin = rem_fin;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      shreg    <= '0;
      divisor  <= '0;
      rem      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op       <= bus.funct3;
            neg_main <= neg_main_c;
            neg_rem  <= neg_rem_c;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            mcand    <= {{XLEN{1'b0}}, a_abs_c};
            divisor  <= b_abs_c;
            // multiplies shift the multiplier out, divides shift the dividend out
            shreg    <= bus.funct3[2] ? a_abs_c : b_abs_c;
            busy_q   <= 1'b1;
            if (special_c) begin
              state    <= FINISH;
              result_q <= special_res_c;
              done_q   <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op[2]) begin
            rem   <= rem_nx;
            shreg <= quo_nx;
          end else begin
            acc   <= mul_acc_nx;
            mcand <= mcand << 1;
            shreg <= mplier_nx;
          end
          if (last_c) begin
            state    <= FINISH;
            result_q <= res_fin;
            done_q   <= 1'b1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit for the multicycle core.
- Successor to the combinational ALU-control decode path: decodes funct3 for funct7=0000001 (M-extension) operations, then runs a multi-cycle shift-add / restoring-divide datapath.
- Width is parametrised by XLEN; the main FSM holds in its execute state until done.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  XLEN  rs1 value.
- operand_b  in  XLEN  rs2 value.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  single-cycle completion pulse.
- result  out  XLEN  result; held stable from done until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; busy=0, done=0, result=0, counter=0, internal registers cleared. Reset mid-operation abandons the operation; no done is issued.
- FSM states: IDLE, CALC, FINISH.
- IDLE & start: latch funct3 and operands, then compute sign flags and absolute values as required by the op (MULH: both signed; MULHSU: a signed only; DIV/REM: both signed; U-ops: unsigned).
  - Go to CALC with counter=0.
  - Special cases go directly to FINISH instead.
- CALC: one iteration per cycle, exactly XLEN iterations.
  - Mul: shift-add of |a| by |b|, 2*XLEN-bit accumulator.
  - Div: restoring, one quotient bit per cycle, XLEN+1-bit remainder.
  - After iteration XLEN-1, go to FINISH.
- FINISH: apply sign correction and load result.
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the 2*XLEN product, negated (two's complement over 2*XLEN bits) when the operand signs differ.
  - DIV: quotient negated if signs differ. REM: remainder takes the dividend's sign.
  - done=1 for this one cycle; next state IDLE.
- Latency: acceptance edge = edge 1. Normal ops: done high in the cycle after edge XLEN+1. Special cases: done high in the cycle after edge 1.
- Throughput: back-to-back requests accepted at most every XLEN+2 cycles.
- start while busy: ignored, no queuing. Operand and funct3 changes after acceptance have no effect.
- Special cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = operand_a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV = operand_a, REM = 0.
- Non-M funct3 values do not exist (3-bit field is fully decoded).

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in multiply CALC, exit to FINISH as soon as the remaining unshifted multiplier bits are all zero. Latency becomes data-dependent; minimum is done in the cycle after edge 2 (b=0 or 1). Results are identical.
- Undefined: fixed XLEN iterations for every non-special op.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 op localparams (OP_MUL … OP_REMU).
  - FSM state encoding typedef (IDLE=2'd0, CALC=2'd1, FINISH=2'd2).
  - Constant FUNCT7_MULDIV = 7'b0000001 for the upstream decoder.
- One natural sub-module, muldiv_operand_prep: combinational sign extraction, absolute value, and special-case detection. The top module holds the FSM, counter and datapath registers.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done in the cycle after edge 33; busy high for 33 cycles.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Each special case: done in the cycle after edge 1.
- start pulsed again at edge 10 of a DIV -> ignored; the original result is unchanged. Then assert rst at edge 20 -> busy=0 and result=0 immediately; no done pulse.
- With MULDIV_EARLY_OUT_EN: MUL 12345 × 1 -> 12345, done in the cycle after edge 2. Without the macro, the same op completes after edge 33.
